pc_sequencer: RTL and testbench

Instruction fetch and PC sequencer for the single-cycle CPU: the upstream end of the instruction-decode interface. It fetches 16-bit instruction words from instruction memory over a request/acknowledge handshake, presents each word on `IR` for one execute cycle, and consumes the decoder's `choosePCUpdate` and `ldRA` responses to compute the next PC and maintain the link register. Sits between instruction memory and the control decoder.

---
 rtl/pc_sequencer.sv | 137 +++++++++++++
 tb/tb_pc_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Instruction fetch and PC sequencer: fetches 16-bit words over a req/ack handshake,
// presents them for one execute cycle, and updates pc/ra from the decoder's response.
// Optional fetch watchdog enabled by defining PC_SEQ_WATCHDOG_EN.
module pc_sequencer #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic [15:0]       IR,
    output logic              ir_valid,
    input  logic [1:0]        choosePCUpdate,
    input  logic              ldRA,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] ra,
    output logic              halted,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } seqState_t;

    localparam logic [1:0] SelHalt = 2'd0;
    localparam logic [1:0] SelJump = 2'd1;
    localparam logic [1:0] SelNext = 2'd2;
    localparam logic [1:0] SelRet  = 2'd3;

    if (ADDR_W == 0 || ADDR_W > 11 || WDOG_MAX == 0 || WDOG_MAX > 255) begin : gBadParams
        $error("pc_sequencer: ADDR_W must be 1..11 and WDOG_MAX 1..255");
    end

    seqState_t         state;
    logic [ADDR_W-1:0] pcPlusOne;

    assign pcPlusOne = pc + ADDR_W'(1);
    assign imem_addr = pc;

`ifdef PC_SEQ_WATCHDOG_EN
    localparam int unsigned WdogW    = 8;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(WDOG_MAX - 1);

    logic [WdogW-1:0] wdogCnt;
`else
    assign fault = 1'b0;
`endif

    // Sequencer FSM; all control outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            ra       <= '0;
            IR       <= 16'h0000;
            ir_valid <= 1'b0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
`ifdef PC_SEQ_WATCHDOG_EN
            wdogCnt  <= '0;
            fault    <= 1'b0;
`endif
        end else begin
            ir_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
`ifdef PC_SEQ_WATCHDOG_EN
                        wdogCnt  <= '0;
`endif
                    end
                end

                FETCH: begin
                    if (imem_ack) begin
                        IR       <= imem_rdata;
                        ir_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= EXEC;
`ifdef PC_SEQ_WATCHDOG_EN
                    end else if (wdogCnt == WdogLast) begin
                        // Memory never answered: stop for good and flag it.
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
                        fault    <= 1'b1;
                        state    <= HALT;
                    end else begin
                        wdogCnt  <= wdogCnt + WdogW'(1);
`endif
                    end
                end

                EXEC: begin
                    if (ldRA) begin
                        ra <= pcPlusOne;
                    end
                    // A return reads ra before any same-cycle link update lands.
                    case (choosePCUpdate)
                        SelJump: pc <= IR[ADDR_W-1:0];
                        SelNext: pc <= pcPlusOne;
                        SelRet:  pc <= ra;
                        default: pc <= pc;
                    endcase
                    if (choosePCUpdate == SelHalt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= FETCH;
`ifdef PC_SEQ_WATCHDOG_EN
                        wdogCnt  <= '0;
`endif
                    end
                end

                HALT: begin
                    state <= HALT;
                end

                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, randomized instruction
// stream against an arithmetic pc/ra model, and halt / reset / fetch-timeout sequences.
module tb_pc_sequencer;

    localparam int unsigned ADDR_W   = 11;
    localparam int unsigned WDOG_MAX = 255;
    localparam int          ASPACE   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              run = 1'b0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata = 16'h0000;
    logic              imem_ack = 1'b0;
    logic [15:0]       IR;
    logic              ir_valid;
    logic [1:0]        choosePCUpdate = 2'd0;
    logic              ldRA = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ra;
    logic              halted;
    logic              fault;

    pc_sequencer #(.ADDR_W(ADDR_W), .WDOG_MAX(WDOG_MAX)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .IR(IR), .ir_valid(ir_valid), .choosePCUpdate(choosePCUpdate), .ldRA(ldRA),
        .pc(pc), .ra(ra), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int nPass  = 0;
    int nTotal = 0;
    int curPc  = 0;
    int curRa  = 0;

    typedef struct {
        logic [15:0] word;
        int          waits;
        logic [1:0]  sel;
        logic        link;
        int          expPc;
        int          expRa;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference: next pc/ra straight from the decoder select rules.
    function automatic int modelPc(input int p, input int r, input logic [15:0] w, input logic [1:0] s);
        case (s)
            2'd1:    return int'(w) % ASPACE;
            2'd2:    return (p + 1) % ASPACE;
            2'd3:    return r;
            default: return p;
        endcase
    endfunction

    function automatic int modelRa(input int p, input int r, input logic link);
        return link ? (p + 1) % ASPACE : r;
    endfunction

    // One instruction from a FETCH cycle (called at a negedge) through its EXEC.
    task automatic runInstr(input string tag, input logic [15:0] w, input int waits,
                            input logic [1:0] sel, input logic link, input int expPc, input int expRa);
        check({tag, ".req"}, imem_req, 1);
        check({tag, ".addr"}, imem_addr, curPc);
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 16'($urandom);
            @(negedge clk);
            check({tag, ".waitReq"}, {imem_req, ir_valid}, 2'b10);
        end
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        check({tag, ".irValid"}, ir_valid, 1);
        check({tag, ".ir"}, IR, w);
        check({tag, ".reqInExec"}, imem_req, 0);
        choosePCUpdate = sel;
        ldRA           = link;
        @(negedge clk);
        choosePCUpdate = 2'($urandom);
        ldRA           = 1'($urandom);
        check({tag, ".pc"}, pc, expPc);
        check({tag, ".ra"}, ra, expRa);
        check({tag, ".irHold"}, {IR, ir_valid}, {w, 1'b0});
        check({tag, ".halted"}, halted, (sel == 2'd0));
        check({tag, ".reqAfter"}, imem_req, (sel != 2'd0));
        curPc = expPc;
        curRa = expRa;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        curPc = 0;
        curRa = 0;
    endtask

    task automatic startRun();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{16'h4105, 2, 2'd2, 1'b0, 12'h001, 0};
        vecs[1]  = '{16'hF87B, 0, 2'd1, 1'b0, 12'h07B, 0};
        vecs[2]  = '{16'h0005, 1, 2'd1, 1'b0, 12'h005, 0};
        vecs[3]  = '{16'hD820, 0, 2'd1, 1'b1, 12'h020, 6};
        vecs[4]  = '{16'h1234, 3, 2'd2, 1'b0, 12'h021, 6};
        vecs[5]  = '{16'h0000, 0, 2'd3, 1'b0, 12'h006, 6};
        vecs[6]  = '{16'h0000, 0, 2'd3, 1'b1, 12'h006, 7};
        vecs[7]  = '{16'hFFFF, 1, 2'd3, 1'b1, 12'h007, 7};
        vecs[8]  = '{16'h07FF, 0, 2'd1, 1'b0, 12'h7FF, 7};
        vecs[9]  = '{16'h2222, 0, 2'd2, 1'b1, 12'h000, 0};
        vecs[10] = '{16'h0003, 2, 2'd1, 1'b0, 12'h003, 0};

        // Reset values while rst is held.
        @(negedge clk);
        check("rst.outs", {imem_req, ir_valid, halted, fault}, 4'b0000);
        check("rst.pc", pc, 0);
        check("rst.ra", ra, 0);
        check("rst.ir", IR, 16'h0000);
        rst = 1'b0;

        // IDLE ignores acks and stays put without run.
        imem_ack = 1'b1;
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        check("idle.hold", {imem_req, ir_valid, IR}, 18'h0);

        startRun();
        foreach (vecs[i])
            runInstr($sformatf("vec%0d", i), vecs[i].word, vecs[i].waits, vecs[i].sel,
                     vecs[i].link, vecs[i].expPc, vecs[i].expRa);

        // Random instruction stream against the model.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] w;
            logic [1:0]  s;
            logic        l;
            int          wt;
            w  = 16'($urandom);
            s  = 2'(1 + $urandom_range(0, 2));
            l  = 1'($urandom);
            wt = $urandom_range(0, 3);
            runInstr($sformatf("rnd%0d", n), w, wt, s, l,
                     modelPc(curPc, curRa, w, s), modelRa(curPc, curRa, l));
        end

        // Halt, then run pulses and acks must not restart fetching.
        begin
            int bad;
            int haltPc;
            haltPc = curPc;
            runInstr("halt", 16'hABCD, 1, 2'd0, 1'b0, curPc, curRa);
            bad = 0;
            for (int i = 0; i < 50; i++) begin
                run      = 1'($urandom);
                imem_ack = 1'($urandom);
                @(negedge clk);
                if (imem_req !== 1'b0 || halted !== 1'b1 || ir_valid !== 1'b0) bad++;
            end
            run      = 1'b0;
            imem_ack = 1'b0;
            check("halt.stuckCycles", bad, 0);
            check("halt.pc", pc, haltPc);
        end

        // Asynchronous reset mid-FETCH with an ack pending.
        doReset();
        startRun();
        runInstr("preRst", 16'h0123, 0, 2'd1, 1'b1, 12'h123, 1);
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        #2 rst = 1'b1;
        #1;
        check("arst.outs", {imem_req, ir_valid, halted, fault}, 4'b0000);
        check("arst.pcra", {pc, ra}, 22'h0);
        check("arst.ir", IR, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("arst.ackDiscarded", {imem_req, ir_valid, IR}, 18'h0);
        curPc = 0;
        curRa = 0;

        // Fetch timeout: no ack for 300 cycles.
        begin
            int reqCycles;
            doReset();
            startRun();
            reqCycles = 0;
            for (int i = 0; i < 300; i++) begin
                if (imem_req === 1'b1) reqCycles++;
                @(negedge clk);
            end
`ifdef PC_SEQ_WATCHDOG_EN
            check("wdog.reqCycles", reqCycles, WDOG_MAX);
            check("wdog.fault", fault, 1);
            check("wdog.halted", halted, 1);
            check("wdog.req", imem_req, 0);
`else
            check("wdog.reqCycles", reqCycles, 300);
            check("wdog.fault", fault, 0);
            check("wdog.halted", halted, 0);
            check("wdog.req", imem_req, 1);
`endif
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
